// File: rtl/model_matrix_gen.sv
// Sequential model-matrix generator: translate * rotate(axis, angle) * scale.
// Angle reduction, iterative CORDIC sin/cos, then saturating scale multiply.
module model_matrix_gen #(
   parameter int WI    = 8,
   parameter int WF    = 8,
   parameter int AWI   = 4,
   parameter int AWF   = 8,
   parameter int ITERS = 12,
   parameter int GUARD = 4
) (
   input  logic                      Clk,
   input  logic                      Reset,
   input  logic                      start,
   input  logic [1:0]                axis,
   input  logic [AWI+AWF-1:0]        angle,
   input  logic [WI+WF-1:0]          scale,
   input  logic [WI+WF-1:0]          x_translate,
   input  logic [WI+WF-1:0]          y_translate,
   input  logic [WI+WF-1:0]          z_translate,
   output logic                      busy,
   output logic                      done,
   output logic                      overflow,
   output logic [15:0][WI+WF-1:0]    model_matrix
);

   localparam int W  = WI + WF;
   localparam int AW = AWI + AWF;
   localparam int AF = AWF + GUARD;
   localparam int CF = WF + GUARD;
   localparam int ZW = AWI + AF + 1;
   localparam int XW = CF + 4;
   localparam int PW = W + XW;

   // Constants are held with 24 fraction bits and rounded to the datapath width.
   function automatic logic [31:0] f_q24(input logic [31:0] v, input int fb);
      return (v + (32'd1 << (23 - fb))) >> (24 - fb);
   endfunction

   localparam logic signed [ZW-1:0] PI   = ZW'(f_q24(32'd52707179, AF));
   localparam logic signed [ZW-1:0] PI2  = ZW'(f_q24(32'd26353589, AF));
   localparam logic signed [XW-1:0] K0   = XW'(f_q24(32'd10188013, CF));
   localparam logic signed [XW-1:0] CONE = XW'(1 << CF);
   localparam logic signed [PW-1:0] HALF = PW'(1 << (CF - 1));
   localparam logic signed [PW-1:0] SMAX = PW'((1 << (W - 1)) - 1);
   localparam logic signed [PW-1:0] SMIN = -SMAX - PW'(1);
   localparam logic [W-1:0]         ONE  = W'(1 << WF);

   function automatic logic signed [ZW-1:0] f_atan(input logic [3:0] i);
      logic [31:0] v;
      case (i)
         4'd0:    v = 32'd13176795;
         4'd1:    v = 32'd7778716;
         4'd2:    v = 32'd4110060;
         4'd3:    v = 32'd2086331;
         4'd4:    v = 32'd1047214;
         4'd5:    v = 32'd524117;
         4'd6:    v = 32'd262123;
         4'd7:    v = 32'd131069;
         4'd8:    v = 32'd65536;
         4'd9:    v = 32'd32768;
         4'd10:   v = 32'd16384;
         4'd11:   v = 32'd8192;
         4'd12:   v = 32'd4096;
         4'd13:   v = 32'd2048;
         4'd14:   v = 32'd1024;
         default: v = 32'd512;
      endcase
      return ZW'(f_q24(v, AF));
   endfunction

   function automatic logic [W:0] f_sat(input logic signed [PW-1:0] v);
      if (v > SMAX) return {1'b1, W'(SMAX)};
      if (v < SMIN) return {1'b1, W'(SMIN)};
      return {1'b0, W'(v)};
   endfunction

   typedef enum logic [1:0] {
      S_IDLE,
      S_REDUCE,
      S_CORDIC,
      S_SCALE
   } state_t;

   state_t r_state, w_next;
   logic   w_accept, w_reduce, w_rot, w_scale;

   logic [1:0]           r_axis;
   logic [AW-1:0]        r_angle;
   logic signed [W-1:0]  r_scale;
   logic [W-1:0]         r_tx, r_ty, r_tz;
   logic signed [XW-1:0] r_x, r_y;
   logic signed [ZW-1:0] r_z;
   logic [3:0]           r_iter;
   logic                 r_neg, r_jovf, r_pend;
   logic [W-1:0]         r_sc, r_ss, r_nss;
   logic                 r_busy, r_done, r_ovf;
   logic [15:0][W-1:0]   r_mat;

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next   = r_state;
      w_accept = 1'b0;
      w_reduce = 1'b0;
      w_rot    = 1'b0;
      w_scale  = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_accept = 1'b1;
               w_next   = S_REDUCE;
            end
         end
         S_REDUCE: begin
            w_reduce = 1'b1;
            w_next   = S_CORDIC;
         end
         S_CORDIC: begin
            w_rot = 1'b1;
            if (r_iter == 4'(ITERS - 1)) w_next = S_SCALE;
         end
         default: begin
            w_scale = 1'b1;
            w_next  = S_IDLE;
         end
      endcase
   end

   logic signed [ZW-1:0] w_aext, w_acl, w_z0;
   logic                 w_clamp, w_fold;

   assign w_aext = {r_angle[AW-1], r_angle, {GUARD{1'b0}}};

   // Fold into [-pi/2, pi/2]; the half-turn is undone by negating sin and cos.
   always_comb begin
      w_clamp = 1'b0;
      w_acl   = w_aext;
      if (w_aext > PI) begin
         w_acl   = PI;
         w_clamp = 1'b1;
      end else if (w_aext < -PI) begin
         w_acl   = -PI;
         w_clamp = 1'b1;
      end
      w_fold = 1'b0;
      w_z0   = w_acl;
      if (w_acl > PI2) begin
         w_z0   = w_acl - PI;
         w_fold = 1'b1;
      end else if (w_acl < -PI2) begin
         w_z0   = w_acl + PI;
         w_fold = 1'b1;
      end
   end

   logic signed [XW-1:0] w_xs, w_ys;
   logic signed [ZW-1:0] w_at;

   assign w_xs = r_x >>> r_iter;
   assign w_ys = r_y >>> r_iter;
   assign w_at = f_atan(r_iter);

   logic signed [XW-1:0] w_c, w_s;
   logic signed [PW-1:0] w_pc, w_ps, w_rc, w_rs;
   logic [W:0]           w_satc, w_sats, w_satn;

   assign w_c = (r_axis == 2'd3) ? CONE : (r_neg ? -r_x : r_x);
   assign w_s = (r_axis == 2'd3) ? '0   : (r_neg ? -r_y : r_y);

   assign w_pc = $signed({{XW{r_scale[W-1]}}, r_scale}) *
                 $signed({{W{w_c[XW-1]}}, w_c});
   assign w_ps = $signed({{XW{r_scale[W-1]}}, r_scale}) *
                 $signed({{W{w_s[XW-1]}}, w_s});

   assign w_rc   = (w_pc + HALF) >>> CF;
   assign w_rs   = (w_ps + HALF) >>> CF;
   assign w_satc = f_sat(w_rc);
   assign w_sats = f_sat(w_rs);
   assign w_satn = f_sat(-w_rs);

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         r_axis  <= '0;
         r_angle <= '0;
         r_scale <= '0;
         r_tx    <= '0;
         r_ty    <= '0;
         r_tz    <= '0;
         r_x     <= '0;
         r_y     <= '0;
         r_z     <= '0;
         r_iter  <= '0;
         r_neg   <= 1'b0;
         r_jovf  <= 1'b0;
         r_sc    <= '0;
         r_ss    <= '0;
         r_nss   <= '0;
      end else begin
         if (w_accept) begin
            r_axis  <= axis;
            r_angle <= angle;
            r_scale <= scale;
            r_tx    <= x_translate;
            r_ty    <= y_translate;
            r_tz    <= z_translate;
         end
         if (w_reduce) begin
            r_x    <= K0;
            r_y    <= '0;
            r_z    <= w_z0;
            r_neg  <= w_fold;
            r_iter <= '0;
            r_jovf <= w_clamp;
         end
         if (w_rot) begin
            if (!r_z[ZW-1]) begin
               r_x <= r_x - w_ys;
               r_y <= r_y + w_xs;
               r_z <= r_z - w_at;
            end else begin
               r_x <= r_x + w_ys;
               r_y <= r_y - w_xs;
               r_z <= r_z + w_at;
            end
            r_iter <= r_iter + 4'd1;
         end
         if (w_scale) begin
            r_sc   <= w_satc[W-1:0];
            r_ss   <= w_sats[W-1:0];
            r_nss  <= w_satn[W-1:0];
            r_jovf <= r_jovf | w_satc[W] | w_sats[W] | w_satn[W];
         end
      end
   end

   logic [15:0][W-1:0] w_mat;

   always_comb begin
      w_mat     = '0;
      w_mat[3]  = r_tx;
      w_mat[7]  = r_ty;
      w_mat[11] = r_tz;
      w_mat[15] = ONE;
      case (r_axis)
         2'd0: begin
            w_mat[0]  = r_scale;
            w_mat[5]  = r_sc;
            w_mat[6]  = r_nss;
            w_mat[9]  = r_ss;
            w_mat[10] = r_sc;
         end
         2'd1: begin
            w_mat[0]  = r_sc;
            w_mat[2]  = r_ss;
            w_mat[5]  = r_scale;
            w_mat[8]  = r_nss;
            w_mat[10] = r_sc;
         end
         2'd2: begin
            w_mat[0]  = r_sc;
            w_mat[1]  = r_nss;
            w_mat[4]  = r_ss;
            w_mat[5]  = r_sc;
            w_mat[10] = r_scale;
         end
         default: begin
            w_mat[0]  = r_scale;
            w_mat[5]  = r_scale;
            w_mat[10] = r_scale;
         end
      endcase
   end

   // The write happens one edge after SCALE, with the FSM already idle,
   // so a new job can be accepted on the same edge that done rises.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         r_pend <= 1'b0;
         r_done <= 1'b0;
         r_ovf  <= 1'b0;
         r_busy <= 1'b0;
         r_mat  <= '0;
         r_mat[0]  <= ONE;
         r_mat[5]  <= ONE;
         r_mat[10] <= ONE;
         r_mat[15] <= ONE;
      end else begin
         r_pend <= w_scale;
         r_done <= r_pend;
         if (r_pend) begin
            r_mat <= w_mat;
            r_ovf <= r_jovf;
         end
         if (w_accept)    r_busy <= 1'b1;
         else if (r_pend) r_busy <= 1'b0;
      end
   end

   assign busy         = r_busy;
   assign done         = r_done;
   assign overflow     = r_ovf;
   assign model_matrix = r_mat;

endmodule

// File: tb/tb_model_matrix_gen.sv
// Directed bench for model_matrix_gen at default parameters.
// Expected values are hand-derived fixed-point constants.
module tb_model_matrix_gen;

   logic              Clk = 1'b0;
   logic              Reset;
   logic              start;
   logic [1:0]        axis;
   logic [11:0]       angle;
   logic [15:0]       scale, xt, yt, zt;
   logic              busy, done, overflow;
   logic [15:0][15:0] mm;

   int n_vec = 0;
   int n_err = 0;

   always #5 Clk = ~Clk;

   model_matrix_gen dut (
      .Clk          (Clk),
      .Reset        (Reset),
      .start        (start),
      .axis         (axis),
      .angle        (angle),
      .scale        (scale),
      .x_translate  (xt),
      .y_translate  (yt),
      .z_translate  (zt),
      .busy         (busy),
      .done         (done),
      .overflow     (overflow),
      .model_matrix (mm)
   );

   task automatic check(input string tag, input int obs,
                        input int exp, input int tol = 0);
      int d;
      n_vec++;
      d = obs - exp;
      if (d < 0) d = -d;
      if (d > tol) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (tol %0d)",
                  tag, obs, exp, tol);
      end
   endtask

   function automatic int el(input int i);
      return int'($signed(mm[i]));
   endfunction

   task automatic setup(input logic [1:0] a, input logic [11:0] g,
                        input logic [15:0] s, input logic [15:0] x,
                        input logic [15:0] y, input logic [15:0] z);
      axis  = a;
      angle = g;
      scale = s;
      xt    = x;
      yt    = y;
      zt    = z;
   endtask

   task automatic launch(input logic [1:0] a, input logic [11:0] g,
                         input logic [15:0] s, input logic [15:0] x,
                         input logic [15:0] y, input logic [15:0] z,
                         input bit hold);
      @(negedge Clk);
      setup(a, g, s, x, y, z);
      start = 1'b1;
      @(posedge Clk);
      #1;
      if (!hold) start = 1'b0;
   endtask

   task automatic wait_done(output int lat);
      lat = -1;
      for (int k = 1; k <= 40; k++) begin
         @(posedge Clk);
         #1;
         if (done) begin
            lat = k;
            break;
         end
      end
   endtask

   int lat, nd, t1, t2, m0a, m0b, m2b, bz;
   int exp1 [16];

   initial begin
      Reset = 1'b1;
      start = 1'b0;
      setup(2'd0, 12'h000, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
      repeat (3) @(posedge Clk);
      #1;
      check("rst_busy", int'(busy), 0);
      check("rst_done", int'(done), 0);
      check("rst_ovf", int'(overflow), 0);
      check("rst_m0", el(0), 256);
      check("rst_m1", el(1), 0);
      check("rst_m5", el(5), 256);
      check("rst_m10", el(10), 256);
      check("rst_m15", el(15), 256);
      Reset = 1'b0;
      @(posedge Clk);
      #1;

      // Y axis, angle 0: identity within CORDIC error
      launch(2'd1, 12'h000, 16'h0100, 16'h0, 16'h0, 16'h0, 1'b0);
      check("t1_busy", int'(busy), 1);
      wait_done(lat);
      check("t1_lat", lat, 15);
      exp1 = '{256, 0, 0, 0, 0, 256, 0, 0, 0, 0, 256, 0, 0, 0, 0, 256};
      for (int i = 0; i < 16; i++) check($sformatf("t1_m%0d", i), el(i), exp1[i], 2);
      check("t1_ovf", int'(overflow), 0);
      @(posedge Clk);
      #1;
      check("t1_pulse", int'(done), 0);
      check("t1_idle", int'(busy), 0);

      // Y axis, pi/2, scale 2.0, x 3.0
      launch(2'd1, 12'h192, 16'h0200, 16'h0300, 16'h0, 16'h0, 1'b0);
      wait_done(lat);
      check("t2_lat", lat, 15);
      check("t2_m0", el(0), 0, 2);
      check("t2_m2", el(2), 512, 2);
      check("t2_m8", el(8), -512, 2);
      check("t2_m3", el(3), 16'h0300);
      check("t2_m5", el(5), 512);
      check("t2_ovf", int'(overflow), 0);

      // Saturation: scale -128 at pi/2
      launch(2'd1, 12'h192, 16'h8000, 16'h0, 16'h0, 16'h0, 1'b0);
      wait_done(lat);
      check("t4_m8", el(8), 32767);
      check("t4_m2", el(2), -32768);
      check("t4_ovf", int'(overflow), 1);

      // Angle beyond pi clamps to pi
      launch(2'd1, 12'h400, 16'h0100, 16'h0, 16'h0, 16'h0, 1'b0);
      wait_done(lat);
      check("t4c_ovf", int'(overflow), 1);
      check("t4c_m0", el(0), -256, 2);
      check("t4c_m10", el(10), -256, 2);

      // Z axis, -pi
      launch(2'd2, 12'hCDC, 16'h0100, 16'h0, 16'h0, 16'h0, 1'b0);
      wait_done(lat);
      check("t3z_m0", el(0), -256, 2);
      check("t3z_m1", el(1), 0, 2);
      check("t3z_m5", el(5), -256, 2);
      check("t3z_m10", el(10), 256);
      check("t3z_ovf", int'(overflow), 0);

      // X axis, -pi
      launch(2'd0, 12'hCDC, 16'h0100, 16'h0, 16'h0, 16'h0, 1'b0);
      wait_done(lat);
      check("t3x_m5", el(5), -256, 2);
      check("t3x_m10", el(10), -256, 2);
      check("t3x_m0", el(0), 256);
      check("t3x_m6", el(6), 0, 2);

      // No rotation: scale and translate only
      launch(2'd3, 12'h192, 16'h0180, 16'h0010, 16'hFFF0, 16'h0020, 1'b0);
      wait_done(lat);
      check("t3n_m0", el(0), 16'h0180);
      check("t3n_m5", el(5), 16'h0180);
      check("t3n_m10", el(10), 16'h0180);
      check("t3n_m2", el(2), 0);
      check("t3n_m7", el(7), -16);
      check("t3n_m11", el(11), 32);
      check("t3n_ovf", int'(overflow), 0);

      // Start while busy is ignored
      launch(2'd1, 12'h000, 16'h0100, 16'h0, 16'h0, 16'h0, 1'b0);
      nd = 0;
      t1 = -1;
      m0a = 0;
      for (int k = 1; k <= 35; k++) begin
         @(posedge Clk);
         #1;
         if (done) begin
            nd++;
            if (t1 < 0) begin
               t1 = k;
               m0a = el(0);
            end
         end
         if (k == 4) begin
            angle = 12'h192;
            start = 1'b1;
         end
         if (k == 5) start = 1'b0;
      end
      check("t5_ndone", nd, 1);
      check("t5_lat", t1, 15);
      check("t5_m0", m0a, 256, 2);

      // Start held through done: back-to-back jobs
      launch(2'd2, 12'h000, 16'h0100, 16'h0, 16'h0, 16'h0, 1'b1);
      setup(2'd1, 12'h192, 16'h0200, 16'h0300, 16'h0, 16'h0);
      t1 = -1;
      t2 = -1;
      bz = 0;
      m0a = 0;
      m0b = 0;
      m2b = 0;
      for (int k = 1; k <= 40; k++) begin
         @(posedge Clk);
         #1;
         if (done) begin
            if (t1 < 0) begin
               t1 = k;
               m0a = el(0);
               bz = int'(busy);
               start = 1'b0;
            end else if (t2 < 0) begin
               t2 = k;
               m0b = el(0);
               m2b = el(2);
            end
         end
      end
      check("t5b_lat1", t1, 15);
      check("t5b_busy", bz, 1);
      check("t5b_lat2", t2, 30);
      check("t5b_m0a", m0a, 256, 2);
      check("t5b_m0b", m0b, 0, 2);
      check("t5b_m2b", m2b, 512, 2);

      // Reset mid-job aborts
      launch(2'd1, 12'h192, 16'h0200, 16'h0, 16'h0, 16'h0, 1'b0);
      nd = 0;
      for (int k = 1; k <= 30; k++) begin
         @(posedge Clk);
         #1;
         if (done) nd++;
         if (k == 6) Reset = 1'b1;
         if (k == 8) Reset = 1'b0;
      end
      check("t6_ndone", nd, 0);
      check("t6_busy", int'(busy), 0);
      check("t6_m0", el(0), 256);
      check("t6_m2", el(2), 0);
      check("t6_m5", el(5), 256);
      check("t6_ovf", int'(overflow), 0);

      launch(2'd0, 12'h000, 16'h0300, 16'h0, 16'h0, 16'h0, 1'b0);
      wait_done(lat);
      check("t6f_lat", lat, 15);
      check("t6f_m0", el(0), 16'h0300);
      check("t6f_m5", el(5), 768, 2);
      check("t6f_m9", el(9), 0, 2);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
